// File: rtl/ramspx_arb.sv
// ramspx_arb: zero-fills a single-port RAM, then arbitrates two clients onto it
// with combinational grants, round-robin on ties and a 2-cycle read return.
module ramspx_arb #(
  parameter int ADDRBIT = 11,
  parameter int DEPTH   = 1536,
  parameter int WIDTH   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  output logic               rdy,
  input  logic               a_req,
  input  logic               a_we,
  input  logic [ADDRBIT-1:0] a_addr,
  input  logic [WIDTH-1:0]   a_di,
  output logic               a_gnt,
  output logic               a_rvld,
  output logic [WIDTH-1:0]   a_do,
  input  logic               b_req,
  input  logic               b_we,
  input  logic [ADDRBIT-1:0] b_addr,
  input  logic [WIDTH-1:0]   b_di,
  output logic               b_gnt,
  output logic               b_rvld,
  output logic [WIDTH-1:0]   b_do,
  output logic [ADDRBIT-1:0] ram_a,
  output logic               ram_we,
  output logic [WIDTH-1:0]   ram_di,
  input  logic [WIDTH-1:0]   ram_do
);
  typedef enum logic {INIT, RUN} state_t;
  state_t r_state, w_next;
  logic [ADDRBIT-1:0] r_cnt, w_cnt_nxt;
  logic r_lastg;
  logic r_rda, r_rdb;
  logic w_run, w_ga, w_gb;
  assign w_run = (r_state == RUN);
  // r_lastg: 1 means B was granted most recently
  assign w_ga = w_run & a_req & (~b_req | r_lastg);
  assign w_gb = w_run & b_req & ~w_ga;
  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    if (r_state == INIT) begin
      w_cnt_nxt = clr ? '0 : r_cnt + 1'b1;
      if (!clr && r_cnt == ADDRBIT'(DEPTH - 1)) begin
        w_next    = RUN;
        w_cnt_nxt = '0;
      end
    end else if (clr) begin
      w_next    = INIT;
      w_cnt_nxt = '0;
    end
  end
  // the fill write is gated by rst_n so the RAM sees no write while held in reset
  assign rdy    = w_run;
  assign a_gnt  = w_ga;
  assign b_gnt  = w_gb;
  assign ram_we = !w_run ? rst_n : w_ga ? a_we : w_gb ? b_we : 1'b0;
  assign ram_a  = !w_run ? r_cnt : w_ga ? a_addr : w_gb ? b_addr : '0;
  assign ram_di = !w_run ? '0 : w_ga ? a_di : w_gb ? b_di : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= INIT;
      r_cnt   <= '0;
      r_lastg <= 1'b1;
      r_rda   <= 1'b0;
      r_rdb   <= 1'b0;
      a_rvld  <= 1'b0;
      b_rvld  <= 1'b0;
      a_do    <= '0;
      b_do    <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      r_lastg <= w_ga ? 1'b0 : w_gb ? 1'b1 : r_lastg;
      r_rda   <= w_ga & ~a_we;
      r_rdb   <= w_gb & ~b_we;
      a_rvld  <= r_rda;
      b_rvld  <= r_rdb;
      if (r_rda) a_do <= ram_do;
      if (r_rdb) b_do <= ram_do;
    end
  end
endmodule

// File: tb/tb_ramspx_arb.sv
// tb_ramspx_arb: directed checks of fill, arbitration, read latency, clr and reset
// against a behavioural single-port RAM.
module tb_ramspx_arb;
  localparam int AW = 3;
  localparam int DEPTH = 8;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rst_n, clr;
  logic a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [W-1:0] a_di, b_di;
  logic rdy, a_gnt, b_gnt, a_rvld, b_rvld, ram_we;
  logic [W-1:0] a_do, b_do, ram_di;
  logic [W-1:0] ram_do = '0;
  logic [AW-1:0] ram_a;
  logic [W-1:0] mem [DEPTH];
  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ramspx_arb #(.ADDRBIT(AW), .DEPTH(DEPTH), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .rdy(rdy),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_di(a_di),
    .a_gnt(a_gnt), .a_rvld(a_rvld), .a_do(a_do),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_di(b_di),
    .b_gnt(b_gnt), .b_rvld(b_rvld), .b_do(b_do),
    .ram_a(ram_a), .ram_we(ram_we), .ram_di(ram_di), .ram_do(ram_do)
  );

  initial for (int i = 0; i < DEPTH; i++) mem[i] = 32'hA5A5_A5A5;
  always @(posedge clk) begin
    if (ram_we) mem[ram_a] <= ram_di;
    else ram_do <= mem[ram_a];
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0;
    a_req = 0; a_we = 0; a_addr = '0; a_di = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_di = '0;
    repeat (3) cyc;
    check("rst_rdy", rdy, 0);
    check("rst_we", ram_we, 0);
    check("rst_a", ram_a, 0);
    check("rst_di", ram_di, 0);
    check("rst_rvld", {a_rvld, b_rvld}, 0);
    check("rst_do", a_do | b_do, 0);
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      check("fill_we", ram_we, 1);
      check("fill_a", ram_a, i);
      check("fill_di", ram_di, 0);
      check("fill_rdy", rdy, 0);
      cyc;
    end
    #1;
    check("run_rdy", rdy, 1);
    check("idle_we", ram_we, 0);
    check("idle_a", ram_a, 0);

    // both clients reading continuously: A,B,A,B then drain
    a_addr = 5; b_addr = 2;
    for (int k = 0; k < 6; k++) begin
      a_req = (k < 4); b_req = (k < 4);
      #1;
      check("rr_agnt", a_gnt, (k < 4) && (k % 2 == 0));
      check("rr_bgnt", b_gnt, (k < 4) && (k % 2 == 1));
      check("rr_arvld", a_rvld, (k == 2) || (k == 4));
      check("rr_brvld", b_rvld, (k == 3) || (k == 5));
      if (k >= 2) check("rr_do", (k % 2 == 0) ? a_do : b_do, 0);
      cyc;
    end

    // A writes then reads address 5 back-to-back
    a_req = 1; a_we = 1; a_addr = 5; a_di = 32'h1234_5678;
    #1;
    check("aw_gnt", a_gnt, 1);
    check("aw_we", ram_we, 1);
    check("aw_a", ram_a, 5);
    check("aw_di", ram_di, 32'h1234_5678);
    cyc;
    a_we = 0;
    #1;
    check("ar_gnt", a_gnt, 1);
    check("ar_we", ram_we, 0);
    cyc;
    a_req = 0;
    #1;
    check("ar_rvld_t1", a_rvld, 0);
    cyc;
    check("ar_rvld_t2", a_rvld, 1);
    check("ar_do", a_do, 32'h1234_5678);
    check("ar_brvld", b_rvld, 0);
    cyc;
    check("ar_rvld_pulse", a_rvld, 0);
    check("ar_do_hold", a_do, 32'h1234_5678);

    // B writes address 6 so that B becomes the most recent grant
    b_req = 1; b_we = 1; b_addr = 6; b_di = 32'hCAFE_F00D;
    #1;
    check("bw_gnt", b_gnt, 1);
    check("bw_di", ram_di, 32'hCAFE_F00D);
    cyc;
    // A write and B read of address 3 collide
    a_req = 1; a_we = 1; a_addr = 3; a_di = 32'hDEAD_BEEF;
    b_we = 0; b_addr = 3;
    #1;
    check("col_agnt", a_gnt, 1);
    check("col_bgnt", b_gnt, 0);
    check("col_a", ram_a, 3);
    cyc;
    a_req = 0;
    #1;
    check("col_bgnt2", b_gnt, 1);
    check("col_we2", ram_we, 0);
    cyc;
    b_req = 0;
    cyc;
    check("col_brvld", b_rvld, 1);
    check("col_bdo", b_do, 32'hDEAD_BEEF);
    cyc;

    // B read of address 6, then clr the next cycle
    b_req = 1; b_we = 0; b_addr = 6;
    #1;
    check("clr_bgnt", b_gnt, 1);
    cyc;
    b_req = 0; clr = 1;
    #1;
    check("clr_rdy_run", rdy, 1);
    cyc;
    clr = 0;
    a_req = 1; a_we = 1; a_addr = 6; a_di = 32'hFFFF_FFFF;
    check("clr_brvld", b_rvld, 1);
    check("clr_bdo", b_do, 32'hCAFE_F00D);
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      check("refill_rdy", rdy, 0);
      check("refill_a", ram_a, i);
      check("refill_agnt", a_gnt, 0);
      cyc;
    end
    a_req = 0;
    #1;
    check("refill_done", rdy, 1);
    b_req = 1; b_addr = 6;
    #1;
    check("post_bgnt", b_gnt, 1);
    cyc;
    b_req = 0;
    cyc;
    check("post_brvld", b_rvld, 1);
    check("post_bdo", b_do, 0);
    cyc;

    // reset asserted mid-fill at cnt=4
    clr = 1;
    cyc;
    clr = 0;
    repeat (4) cyc;
    check("mid_a", ram_a, 4);
    rst_n = 0;
    #1;
    check("mid_rst_we", ram_we, 0);
    check("mid_rst_a", ram_a, 0);
    check("mid_rst_rdy", rdy, 0);
    check("mid_rst_ado", a_do, 0);
    cyc;
    rst_n = 1;
    #1;
    check("restart_we", ram_we, 1);
    check("restart_a0", ram_a, 0);
    cyc;
    check("restart_a1", ram_a, 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/ramspx_arb.md
RAMSPX_ARB -- requirements
Module: ramspx_arb

Interface
REQ-001 The block SHALL have parameter ADDRBIT, default 11, giving the RAM address width.
REQ-002 The block SHALL have parameter DEPTH, default 1536, giving the number of RAM words in use.
REQ-003 The block SHALL have parameter WIDTH, default 32, giving the data width.
REQ-004 Ports SHALL be exactly as listed below, one clock, reset asynchronous active-low:
- clk  in  1  rising-edge clock, shared with the single-port RAM
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  single-cycle pulse; restarts zero-fill of the RAM
- rdy  out  1  high when the RAM is initialised and client access is open
- a_req / b_req  in  1  client access request
- a_we / b_we  in  1  1 = write, 0 = read
- a_addr / b_addr  in  ADDRBIT  client address
- a_di / b_di  in  WIDTH  client write data
- a_gnt / b_gnt  out  1  access granted this cycle
- a_rvld / b_rvld  out  1  read data valid pulse
- a_do / b_do  out  WIDTH  registered read data
- ram_a  out  ADDRBIT  RAM address
- ram_we  out  1  RAM write enable
- ram_di  out  WIDTH  RAM write data
- ram_do  in  WIDTH  RAM read data; updates 1 clk after a read, holds during writes

Function
REQ-005 The FSM SHALL have two states, INIT and RUN, plus a fill counter cnt (ADDRBIT bits).
REQ-006 INIT SHALL drive ram_we=1, ram_a=cnt, ram_di=0 and increment cnt each cycle; both grants SHALL be 0.
REQ-007 In INIT with cnt==DEPTH-1, the block SHALL complete that write and enter RUN on the next cycle; rdy SHALL be 1 in every RUN cycle.
REQ-008 A clr pulse in RUN SHALL move the FSM to INIT with cnt=0 on the next cycle; rdy SHALL fall in that cycle.
REQ-009 A clr pulse in INIT SHALL reset cnt to 0 on the next cycle, and the fill SHALL restart.
REQ-010 In RUN with exactly one request, that client SHALL be granted combinationally in the same cycle.
REQ-011 In RUN with both requests, the client not granted most recently SHALL be granted; register lastg SHALL record each grant.
REQ-012 In a granted cycle, ram_a, ram_we and ram_di SHALL equal the granted client's addr, we and di.
REQ-013 In RUN with no grant, ram_we SHALL be 0 and ram_a SHALL be 0.
REQ-014 A client SHALL hold req and its command stable until gnt; a new request MAY be presented in the cycle after gnt.
REQ-015 Back-to-back grants to one client SHALL be allowed when the other client is idle.
REQ-016 A granted read in cycle T SHALL capture ram_do into x_do at the end of T+1 and pulse x_rvld for one cycle in T+2; read latency is 2 cycles.
REQ-017 x_do SHALL hold its value between reads.
REQ-018 Writes SHALL produce no response beyond gnt.
REQ-019 A read granted before a clr pulse SHALL still return its x_rvld and x_do.
REQ-020 Read data SHALL reflect every write granted in an earlier cycle.

Reset
REQ-021 While rst_n is low: FSM=INIT, cnt=0, lastg=B (so A wins the first tie), rdy=0, a_gnt=b_gnt=0, a_rvld=b_rvld=0, a_do=b_do=0, ram_we=0, ram_a=0, ram_di=0.
REQ-022 Assertion of rst_n at any point, including mid-INIT or with reads in flight, SHALL apply REQ-021 immediately and discard pending x_rvld.
REQ-023 After release, zero-fill SHALL start at address 0 on the first clock edge.

Verification
REQ-024 DEPTH=8, release reset -> ram_we=1 for 8 cycles with ram_a 0..7 and ram_di=0; rdy=1 in the 9th cycle.
REQ-025 A writes 0x12345678 to address 5, then A reads address 5 -> a_rvld 2 cycles after the read grant, a_do=0x12345678, b_rvld stays 0.
REQ-026 a_req and b_req held high with reads -> grants alternate A,B,A,B starting with A; each rvld follows its gnt by 2 cycles.
REQ-027 A writes 0xDEADBEEF to address 3 while B reads address 3 in the same cycle -> A granted first, B granted next cycle, b_do=0xDEADBEEF.
REQ-028 B read granted, clr in the next cycle -> b_rvld still pulses with the correct data; rdy=0 for DEPTH cycles; a later read of that address returns 0.
REQ-029 rst_n low during INIT at cnt=4 -> all outputs take reset values at once; after release, the fill restarts at address 0.
